// File: rtl/ssd_frame_capture_pkg.sv
// Shared seven-segment constants, digit positions and capture FSM types for
// the display-side frame capture block.
package ssd_frame_capture_pkg;

    // Active-low cathode patterns, bit0 = segment a .. bit6 = segment g.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam int NUM_DIGITS     = 6;
    localparam int DIG_RIGHT_SEC  = 0;
    localparam int DIG_LEFT_SEC   = 1;
    localparam int DIG_RIGHT_MIN  = 2;
    localparam int DIG_LEFT_MIN   = 3;
    localparam int DIG_RIGHT_HOUR = 4;
    localparam int DIG_LEFT_HOUR  = 5;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD
    } cap_state_e;

    typedef enum logic [1:0] {
        AN_BLANK,
        AN_SINGLE,
        AN_COLLISION
    } anode_class_e;

    function automatic anode_class_e classify_anode(input logic [7:0] anode);
        logic [7:0] lit;
        lit = ~anode;
        if (lit == 8'h00) return AN_BLANK;
        if ((lit & (lit - 8'd1)) != 8'h00) return AN_COLLISION;
        return AN_SINGLE;
    endfunction

    function automatic logic [2:0] anode_index(input logic [7:0] anode);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!anode[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ssd_frame_capture_pattern_decode.sv
// Cathode pattern to BCD nibble; the inverse of the clock's segment encoder.
module ssd_pattern_decode
    import ssd_frame_capture_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       valid_o,
    output logic [3:0] nibble_o
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        valid_o  = 1'b1;
        nibble_o = 4'd0;
        case (seg_i)
            SEG_0:   nibble_o = 4'd0;
            SEG_1:   nibble_o = 4'd1;
            SEG_2:   nibble_o = 4'd2;
            SEG_3:   nibble_o = 4'd3;
            SEG_4:   nibble_o = 4'd4;
            SEG_5:   nibble_o = 4'd5;
            SEG_6:   nibble_o = 4'd6;
            SEG_7:   nibble_o = 4'd7;
            SEG_8:   nibble_o = 4'd8;
            SEG_9:   nibble_o = 4'd9;
            default: valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_frame_capture.sv
// Samples a multiplexed seven-segment scan, decodes each settled digit and
// reassembles the BCD time word once every digit of a frame has been seen.
module ssd_frame_capture
    import ssd_frame_capture_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter logic [7:0]  DIGIT_MASK     = 8'h3F,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  anode_in,
    input  logic [7:0]  cathode_in,
    output logic [23:0] time_out,
    output logic        frame_valid,
    output logic        time_changed,
    output logic        decode_error,
    output logic        stale
);

    localparam int               STALE_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALE_W-1:0] STALE_LIMIT = STALE_W'(TIMEOUT_CYCLES);
    localparam logic [STALE_W-1:0] STALE_ONE   = STALE_W'(1);
    localparam logic [7:0]       SETTLE_LIMIT = 8'(SETTLE_CYCLES);
    // Only six slots exist in the time word; higher anode positions never commit.
    localparam logic [7:0]       SLOT_MASK   = DIGIT_MASK & 8'((1 << NUM_DIGITS) - 1);

    logic [7:0] an_s1_q, an_s2_q;
    logic [6:0] ca_s1_q, ca_s2_q;
    logic       dp_unused;

    cap_state_e         state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [7:0]         an_ref_q, an_ref_d;
    logic [6:0]         ca_ref_q, ca_ref_d;
    logic [23:0]        slots_q, slots_d;
    logic [7:0]         mask_q, mask_d;
    logic               bad_q, bad_d;
    logic [23:0]        time_q, time_d;
    logic               fv_q, fv_d;
    logic               tc_q, tc_d;
    logic               err_q, err_d;
    logic               seen_q, seen_d;
    logic [STALE_W-1:0] stale_cnt_q, stale_cnt_d;

    anode_class_e s2_class, ref_class;
    logic [2:0]   ref_idx;
    logic         seg_valid;
    logic [3:0]   seg_nibble;

    assign dp_unused = cathode_in[7];

    // NOTE: both sync stages reset to all-ones so reset reads as a blank display.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_s1_q <= 8'hFF;
            an_s2_q <= 8'hFF;
            ca_s1_q <= 7'h7F;
            ca_s2_q <= 7'h7F;
        end else begin
            an_s1_q <= anode_in;
            an_s2_q <= an_s1_q;
            ca_s1_q <= cathode_in[6:0];
            ca_s2_q <= ca_s1_q;
        end
    end

    assign s2_class  = classify_anode(an_s2_q);
    assign ref_class = classify_anode(an_ref_q);
    assign ref_idx   = anode_index(an_ref_q);

    ssd_pattern_decode u_decode (
        .seg_i    (ca_ref_q),
        .valid_o  (seg_valid),
        .nibble_o (seg_nibble)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        an_ref_d    = an_ref_q;
        ca_ref_d    = ca_ref_q;
        slots_d     = slots_q;
        mask_d      = mask_q;
        bad_d       = bad_q;
        time_d      = time_q;
        fv_d        = 1'b0;
        tc_d        = 1'b0;
        err_d       = err_q;
        seen_d      = seen_q;
        stale_cnt_d = (stale_cnt_q == STALE_LIMIT) ? stale_cnt_q : stale_cnt_q + STALE_ONE;

        case (state_q)
            ST_WAIT: begin
                if (s2_class != AN_BLANK) begin
                    an_ref_d = an_s2_q;
                    ca_ref_d = ca_s2_q;
                    cnt_d    = 8'd1;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (an_s2_q != an_ref_q || ca_s2_q != ca_ref_q) begin
                    an_ref_d = an_s2_q;
                    ca_ref_d = ca_s2_q;
                    cnt_d    = 8'd1;
                    if (s2_class == AN_BLANK) state_d = ST_WAIT;
                end else if (cnt_q >= SETTLE_LIMIT) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SAMPLE: begin
                state_d = ST_HOLD;
                if (ref_class == AN_COLLISION) begin
                    err_d = 1'b1;
                end else if (ref_class == AN_SINGLE && SLOT_MASK[ref_idx]) begin
                    // An undecodable digit still fills its mask bit so the bad
                    // frame completes and is dropped as a whole.
                    mask_d[ref_idx] = 1'b1;
                    if (seg_valid) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (ref_idx == 3'(i)) slots_d[4*i +: 4] = seg_nibble;
                        end
                    end else begin
                        err_d = 1'b1;
                        bad_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (an_s2_q != an_ref_q) begin
                    an_ref_d = an_s2_q;
                    ca_ref_d = ca_s2_q;
                    cnt_d    = 8'd1;
                    state_d  = (s2_class == AN_BLANK) ? ST_WAIT : ST_SETTLE;
                end
            end
            default: state_d = ST_WAIT;
        endcase

        // Commit never coincides with SAMPLE: the last digit's sample is followed by HOLD.
        if (SLOT_MASK != 8'h00 && mask_q == SLOT_MASK) begin
            mask_d = 8'h00;
            bad_d  = 1'b0;
            if (!bad_q) begin
                time_d      = slots_q;
                fv_d        = 1'b1;
                tc_d        = (slots_q != time_q);
                err_d       = 1'b0;
                seen_d      = 1'b1;
                stale_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_WAIT;
            cnt_q       <= 8'd0;
            an_ref_q    <= 8'hFF;
            ca_ref_q    <= 7'h7F;
            slots_q     <= 24'h0;
            mask_q      <= 8'h00;
            bad_q       <= 1'b0;
            time_q      <= 24'h0;
            fv_q        <= 1'b0;
            tc_q        <= 1'b0;
            err_q       <= 1'b0;
            seen_q      <= 1'b0;
            stale_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            an_ref_q    <= an_ref_d;
            ca_ref_q    <= ca_ref_d;
            slots_q     <= slots_d;
            mask_q      <= mask_d;
            bad_q       <= bad_d;
            time_q      <= time_d;
            fv_q        <= fv_d;
            tc_q        <= tc_d;
            err_q       <= err_d;
            seen_q      <= seen_d;
            stale_cnt_q <= stale_cnt_d;
        end
    end

    assign time_out     = time_q;
    assign frame_valid  = fv_q;
    assign time_changed = tc_q;
    assign decode_error = err_q;
    assign stale        = ~seen_q | (stale_cnt_q == STALE_LIMIT);

endmodule
